// File: rtl/falafel_pkg.sv
// Shared types and widths for the falafel request dispatcher.
//   dispatch_op_e    : request opcode presented to the allocator core
//   dispatch_state_e : dispatcher FSM encoding
//   DATA_W           : default request word width
//   DISP_CNT_W       : default statistics counter width
package falafel_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned DISP_CNT_W = 32;

  typedef enum logic {
    OP_ALLOC = 1'b0,
    OP_FREE  = 1'b1
  } dispatch_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ      = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/falafel_rr_arbiter.sv
// Two-requester round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i[1:0]   : request vector (bit 0 = alloc FIFO, bit 1 = free FIFO)
//   en_i         : grant enable; no grant and no pointer update when low
//   gnt_o[1:0]   : one-hot grant, combinational
// The last-grant pointer resets to FREE so the first contended grant is ALLOC.
module falafel_rr_arbiter
  import falafel_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  dispatch_op_e last_q, last_d;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == OP_FREE) ? 2'b01 : 2'b10;
        default: gnt_o = '0;
      endcase
    end
    if (gnt_o[0]) last_d = OP_ALLOC;
    if (gnt_o[1]) last_d = OP_FREE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= OP_FREE;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/falafel_req_dispatcher.sv
// Pulls request words from the alloc and free FIFOs and issues them one at a
// time to the allocator core, counting completions per opcode.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   alloc_fifo_*             : alloc FIFO empty / pop / read data
//   free_fifo_*              : free FIFO empty / pop / read data
//   core_req_val_o/rdy_i     : request handshake to the core
//   core_req_op_o/data_o     : registered opcode and payload
//   core_done_i              : completion pulse from the core
//   alloc_cnt_o, free_cnt_o  : saturating completion counters
//   err_o                    : sticky flag, done seen outside WAIT_DONE
module falafel_req_dispatcher
  import falafel_pkg::*;
#(
  parameter int unsigned DATA_W = falafel_pkg::DATA_W,
  parameter int unsigned CNT_W  = DISP_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_fifo_empty_i,
  output logic              alloc_fifo_read_o,
  input  logic [DATA_W-1:0] alloc_fifo_dout_i,
  input  logic              free_fifo_empty_i,
  output logic              free_fifo_read_o,
  input  logic [DATA_W-1:0] free_fifo_dout_i,
  output logic              core_req_val_o,
  input  logic              core_req_rdy_i,
  output logic              core_req_op_o,
  output logic [DATA_W-1:0] core_req_data_o,
  input  logic              core_done_i,
  output logic [CNT_W-1:0]  alloc_cnt_o,
  output logic [CNT_W-1:0]  free_cnt_o,
  output logic              err_o
);

  dispatch_state_e   state_q, state_d;
  dispatch_op_e      op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0]  free_cnt_q, free_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        gnt;
  logic              arb_en;

  // Gating with rst_i keeps pops and requests quiet in the reset cycle itself.
  assign arb_en = (state_q == ST_IDLE) && !rst_i;

  falafel_rr_arbiter u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({!free_fifo_empty_i, !alloc_fifo_empty_i}),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign alloc_fifo_read_o = gnt[0];
  assign free_fifo_read_o  = gnt[1];
  assign core_req_val_o    = (state_q == ST_ISSUE) && !rst_i;
  assign core_req_op_o     = op_q;
  assign core_req_data_o   = data_q;
  assign alloc_cnt_o       = alloc_cnt_q;
  assign free_cnt_o        = free_cnt_q;
  assign err_o             = err_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    alloc_cnt_d = alloc_cnt_q;
    free_cnt_d  = free_cnt_q;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          op_d    = gnt[1] ? OP_FREE : OP_ALLOC;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        data_d  = (op_q == OP_FREE) ? free_fifo_dout_i : alloc_fifo_dout_i;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (core_req_rdy_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (core_done_i) begin
          if (op_q == OP_FREE) begin
            if (free_cnt_q != '1) free_cnt_d = free_cnt_q + CNT_W'(1);
          end else begin
            if (alloc_cnt_q != '1) alloc_cnt_d = alloc_cnt_q + CNT_W'(1);
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (core_done_i && (state_q != ST_WAIT_DONE)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ALLOC;
      data_q      <= '0;
      alloc_cnt_q <= '0;
      free_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      alloc_cnt_q <= alloc_cnt_d;
      free_cnt_q  <= free_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_falafel_req_dispatcher.sv
module tb_falafel_req_dispatcher;
  import falafel_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_empty, alloc_read, free_empty, free_read;
  logic [DW-1:0] alloc_dout, free_dout;
  logic          val, rdy, op, done;
  logic [DW-1:0] data;
  logic [CW-1:0] alloc_cnt, free_cnt;
  logic          err;

  logic          done_auto, done_man;
  assign done = done_auto | done_man;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] alloc_q[$];
  logic [DW-1:0] free_q[$];
  logic          exp_op_q[$];
  logic [DW-1:0] exp_data_q[$];
  int unsigned   done_delay = 1;
  int unsigned   core_cnt = 0;

  always #5 clk = ~clk;

  falafel_req_dispatcher #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .alloc_fifo_empty_i (alloc_empty),
    .alloc_fifo_read_o  (alloc_read),
    .alloc_fifo_dout_i  (alloc_dout),
    .free_fifo_empty_i  (free_empty),
    .free_fifo_read_o   (free_read),
    .free_fifo_dout_i   (free_dout),
    .core_req_val_o     (val),
    .core_req_rdy_i     (rdy),
    .core_req_op_o      (op),
    .core_req_data_o    (data),
    .core_done_i        (done),
    .alloc_cnt_o        (alloc_cnt),
    .free_cnt_o         (free_cnt),
    .err_o              (err)
  );

  // FIFO models: pop on read, data valid the following cycle.
  always @(posedge clk) begin
    if (alloc_read && alloc_q.size() > 0) begin
      alloc_dout  <= alloc_q.pop_front();
      alloc_empty <= (alloc_q.size() == 0);
    end
    if (free_read && free_q.size() > 0) begin
      free_dout  <= free_q.pop_front();
      free_empty <= (free_q.size() == 0);
    end
  end

  // Core model + scoreboard + read-protocol monitor, sampled mid low phase.
  always begin
    @(negedge clk);
    #2;
    if (alloc_read || free_read) begin
      n_checks++;
      if ((alloc_read && alloc_empty) || (free_read && free_empty) || (alloc_read && free_read)) begin
        n_fail++;
        $display("FAIL read_protocol: alloc_read=%0b alloc_empty=%0b free_read=%0b free_empty=%0b required one read on a non-empty FIFO",
                 alloc_read, alloc_empty, free_read, free_empty);
      end
    end
    done_auto = 1'b0;
    if (core_cnt != 0) begin
      core_cnt--;
      if (core_cnt == 0) done_auto = 1'b1;
    end
    if (val && rdy) begin
      n_checks++;
      if (exp_op_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: op=%0b data=%h accepted with no expected request", op, data);
      end else begin
        logic          eo;
        logic [DW-1:0] ed;
        eo = exp_op_q.pop_front();
        ed = exp_data_q.pop_front();
        if (op !== eo || data !== ed) begin
          n_fail++;
          $display("FAIL scoreboard_order: got op=%0b data=%h, required op=%0b data=%h", op, data, eo, ed);
        end
      end
      core_cnt = done_delay;
    end
  end

  task automatic push_alloc(input logic [DW-1:0] w, input bit expect_it);
    alloc_q.push_back(w);
    alloc_empty = 1'b0;
    if (expect_it) begin exp_op_q.push_back(1'b0); exp_data_q.push_back(w); end
  endtask

  task automatic push_free(input logic [DW-1:0] w, input bit expect_it);
    free_q.push_back(w);
    free_empty = 1'b0;
    if (expect_it) begin exp_op_q.push_back(1'b1); exp_data_q.push_back(w); end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_op_q.size() == 0 && core_cnt == 0 && !done_auto && alloc_q.size() == 0 &&
          free_q.size() == 0 && dut.state_q == ST_IDLE) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d expected requests still pending, required 0", name, exp_op_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b0; done_man = 1'b0; done_auto = 1'b0;
    alloc_empty = 1'b1; free_empty = 1'b1;
    alloc_dout = '0; free_dout = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({alloc_read, free_read, val, op, err} !== 5'b0 || data !== '0 ||
        alloc_cnt !== '0 || free_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rd=%0b%0b val=%0b op=%0b data=%h cnt=%0d/%0d err=%0b, required all zero",
               alloc_read, free_read, val, op, data, alloc_cnt, free_cnt, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_alloc();
    rdy = 1'b1; done_delay = 3;
    @(negedge clk);
    push_alloc(64'h1000, 1);
    #1;
    n_checks++;
    if (alloc_read !== 1'b1 || free_read !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read_cycle0: alloc_read=%0b free_read=%0b, required 1/0", alloc_read, free_read);
    end
    @(negedge clk); #1;
    n_checks++;
    if (val !== 1'b0 || alloc_read !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cycle1: val=%0b alloc_read=%0b, required 0/0", val, alloc_read);
    end
    @(negedge clk); #1;
    n_checks++;
    if (val !== 1'b1 || op !== 1'b0 || data !== 64'h1000) begin
      n_fail++;
      $display("FAIL single_issue_cycle2: val=%0b op=%0b data=%h, required 1/0/1000", val, op, data);
    end
    drain("single");
    n_checks++;
    if (alloc_cnt !== 32'd1 || free_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL single_counts: alloc=%0d free=%0d, required 1/0", alloc_cnt, free_cnt);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    rdy = 1'b1; done_delay = 1;
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      push_alloc(64'hA000 + 64'(i), 1);
      push_free(64'hF000 + 64'(i), 1);
    end
    // Expected order must interleave A,F,A,F: rebuild the expectation queue.
    exp_op_q.delete(); exp_data_q.delete();
    for (int unsigned i = 0; i < 3; i++) begin
      exp_op_q.push_back(1'b0); exp_data_q.push_back(64'hA000 + 64'(i));
      exp_op_q.push_back(1'b1); exp_data_q.push_back(64'hF000 + 64'(i));
    end
    drain("rr");
    n_checks++;
    if (alloc_cnt !== 32'd3 || free_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL rr_counts: alloc=%0d free=%0d, required 3/3", alloc_cnt, free_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] f0;
    bit seen = 0;
    f0 = free_cnt;
    rdy = 1'b0; done_delay = 1;
    @(negedge clk);
    push_free(64'hBEEF, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (val) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_val_timeout: val never rose, required 1");
    end
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin @(negedge clk); #1; end
      n_checks++;
      if (val !== 1'b1 || op !== 1'b1 || data !== 64'hBEEF) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: val=%0b op=%0b data=%h, required 1/1/beef", i, val, op, data);
      end
    end
    @(negedge clk);
    rdy = 1'b1;
    #1;
    n_checks++;
    if (val !== 1'b1 || data !== 64'hBEEF) begin
      n_fail++;
      $display("FAIL bp_accept_cycle6: val=%0b data=%h, required 1/beef", val, data);
    end
    drain("bp");
    n_checks++;
    if (free_cnt !== f0 + 32'd1) begin
      n_fail++;
      $display("FAIL bp_count: free=%0d, required %0d", free_cnt, f0 + 32'd1);
    end
  endtask

  task automatic test_done_in_idle();
    logic [CW-1:0] a0, f0;
    a0 = alloc_cnt; f0 = free_cnt;
    @(negedge clk);
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b1 || alloc_cnt !== a0 || free_cnt !== f0 || dut.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL idle_done: err=%0b cnt=%0d/%0d state=%0d, required 1 %0d/%0d IDLE",
               err, alloc_cnt, free_cnt, dut.state_q, a0, f0);
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_err_sticky: err=%0b, required 1", err);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen = 0;
    rdy = 1'b0;
    @(negedge clk);
    push_alloc(64'h7777, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (val) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rstmid_val_timeout: val never rose, required 1");
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (val !== 1'b0 || alloc_read !== 1'b0 || free_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_reset_cycle: val=%0b rd=%0b%0b, required 0", val, alloc_read, free_read);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (val !== 1'b0 || alloc_cnt !== '0 || free_cnt !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: val=%0b cnt=%0d/%0d err=%0b, required 0 0/0 0", val, alloc_cnt, free_cnt, err);
    end
    @(negedge clk);
    rdy = 1'b1; done_delay = 2;
    push_alloc(64'h2222, 1);
    push_free(64'h3333, 1);
    drain("rstmid");
    n_checks++;
    if (alloc_cnt !== 32'd1 || free_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL rstmid_counts: alloc=%0d free=%0d, required 1/1", alloc_cnt, free_cnt);
    end
  endtask

  task automatic test_saturation();
    rdy = 1'b1; done_delay = 3;
    @(negedge clk);
    force dut.alloc_cnt_q = {CW{1'b1}};
    @(negedge clk);
    release dut.alloc_cnt_q;
    @(negedge clk);
    push_alloc(64'h5555, 1);
    drain("sat");
    n_checks++;
    if (alloc_cnt !== {CW{1'b1}}) begin
      n_fail++;
      $display("FAIL sat_alloc: alloc=%h, required ffffffff", alloc_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_alloc();
    test_round_robin();
    test_backpressure();
    test_done_in_idle();
    test_reset_mid_op();
    test_saturation();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
